seq_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `xout`, which drives the detector's serial input `xin`. Between words it holds a fixed idle level for a configurable gap. An optional even-parity bit can follow each word.

---
 rtl/seq_serializer.sv | 135 +++++++++++++
 tb/tb_seq_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: one accepted WIDTH-bit word is shifted out on xout, one bit per clock, then GAP idle cycles.
// Latency: first bit on xout right after the accept edge. Backpressure: din_ready only in IDLE; define SEQ_SER_PARITY_EN for a trailing even-parity bit.
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    output logic             xout,
    output logic             xout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [7:0]     GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit             HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2
`ifdef SEQ_SER_PARITY_EN
        ,S_PARITY = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             lsb_q;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       gap_cnt;
`ifdef SEQ_SER_PARITY_EN
    logic             parity_q;
`endif

    assign din_ready = reset && (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            lsb_q      <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            xout       <= IDLE_BIT;
            xout_valid <= 1'b0;
            word_done  <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (din_valid) begin
                        // The first bit goes out on the accept edge itself.
                        shreg      <= din;
                        lsb_q      <= lsb_first;
                        bit_cnt    <= LAST_IDX;
                        xout       <= lsb_first ? din[0] : din[WIDTH-1];
                        xout_valid <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
                        parity_q   <= ^din;
`endif
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt != '0) begin
                        shreg   <= lsb_q ? (shreg >> 1) : (shreg << 1);
                        xout    <= lsb_q ? shreg[1] : shreg[WIDTH-2];
                        bit_cnt <= bit_cnt - CNT_ONE;
`ifdef SEQ_SER_PARITY_EN
                        word_done <= 1'b0;
`else
                        word_done <= (bit_cnt == CNT_ONE);
`endif
                    end else begin
`ifdef SEQ_SER_PARITY_EN
                        xout       <= parity_q;
                        xout_valid <= 1'b1;
                        word_done  <= 1'b1;
                        state      <= S_PARITY;
`else
                        xout       <= IDLE_BIT;
                        xout_valid <= 1'b0;
                        if (HAS_GAP) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state   <= S_IDLE;
                        end
`endif
                    end
                end
`ifdef SEQ_SER_PARITY_EN
                S_PARITY: begin
                    xout       <= IDLE_BIT;
                    xout_valid <= 1'b0;
                    if (HAS_GAP) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
`endif
                S_GAP: begin
                    xout       <= IDLE_BIT;
                    xout_valid <= 1'b0;
                    if (gap_cnt == 8'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    xout       <= IDLE_BIT;
                    xout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: accepts push the expected bit stream, a negedge monitor pops and compares.
module tb_seq_serializer;

    localparam int   W        = 8;
    localparam int   GAPC     = 3;
    localparam logic IDLE     = 1'b1;
`ifdef SEQ_SER_PARITY_EN
    localparam int   P        = 1;
`else
    localparam int   P        = 0;
`endif
    localparam int   PERIOD   = 1 + W + P + GAPC;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         lsb_first;
    logic         xout;
    logic         xout_valid;
    logic         word_done;
    logic         busy;

    seq_serializer #(.WIDTH(W), .GAP(GAPC), .IDLE_BIT(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .lsb_first  (lsb_first),
        .xout       (xout),
        .xout_valid (xout_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        b;
        logic        last;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned acc_cyc  = 0;
    int unsigned prev_cyc = 0;
    bit          have_acc = 0;
    bit          have_prev = 0;
    bit          held     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: on every accept, push the word's bits in transmit order with their due cycle.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            q.delete();
            have_acc  = 0;
            have_prev = 0;
            held      = 0;
        end else if (din_valid && din_ready) begin
            if (have_prev && held) chk("accept_period", cyc - prev_cyc, PERIOD);
            prev_cyc  = cyc;
            have_prev = 1;
            held      = 1;
            acc_cyc   = cyc;
            have_acc  = 1;
            for (int k = 0; k < W; k++) begin
                exp_t e;
                e.b    = lsb_first ? din[k] : din[W-1-k];
                e.last = (k == W-1) && (P == 0);
                e.cyc  = cyc + k;
                q.push_back(e);
            end
            if (P == 1) begin
                exp_t e;
                e.b    = ^din;
                e.last = 1'b1;
                e.cyc  = cyc + W;
                q.push_back(e);
            end
        end else if (!din_valid) begin
            held = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_xout", xout, IDLE);
            chk("rst_xout_valid", xout_valid, 0);
            chk("rst_word_done", word_done, 0);
            chk("rst_din_ready", din_ready, 0);
            chk("rst_busy", busy, 0);
        end else begin
            bit exp_busy;
            exp_busy = have_acc && ((cyc - acc_cyc) < (PERIOD - 1));
            chk("busy", busy, exp_busy);
            chk("din_ready", din_ready, !exp_busy);
            if (xout_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("xout_bit", xout, e.b);
                    chk("word_done", word_done, e.last);
                    chk("bit_time", cyc, e.cyc);
                end
            end else begin
                chk("idle_xout", xout, IDLE);
                chk("idle_word_done", word_done, 0);
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input logic lsb, input bit keep);
        bit got;
        din       = w;
        lsb_first = lsb;
        din_valid = 1'b1;
        got       = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            if (din_ready) got = 1;
        end
        #1;
        if (!got) chk("accept_timeout", 0, 1);
        if (!keep) din_valid = 1'b0;
        din       = W'($urandom);
        lsb_first = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            if (!busy && q.size() == 0) done = 1;
        end
        #1;
        chk("drain_timeout", done, 1);
    endtask

    initial begin
        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        lsb_first = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        send(8'b0010_0000, 1'b0, 0);
        wait_idle();
        send(8'b0010_0000, 1'b1, 0);
        wait_idle();

        send(8'hFF, 1'b0, 1);
        send(8'h00, 1'b0, 0);
        wait_idle();

        send(8'hA5, 1'b0, 0);
        wait_idle();
        send(8'h07, 1'b1, 0);
        wait_idle();

        // Abandon a word mid-flight: outputs must drop to idle at once.
        send(8'h55, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk("midrst_xout", xout, IDLE);
        chk("midrst_xout_valid", xout_valid, 0);
        chk("midrst_word_done", word_done, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        send(8'h0F, 1'b0, 0);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            send(W'($urandom), 1'($urandom_range(0, 1)), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        wait_idle();
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
